// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encodings, oversampling, baud divisor.
package uart_tx_scheduler_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned OVERSAMPLE = 16;
  // 9600 baud at 50 MHz with 16x oversampling; also used by baud_rate_generator.
  localparam int unsigned BAUD_DIV_M = 326;
  localparam int unsigned SCNT_W     = 4;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester after 'last', as one-hot plus index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = (32'(last) + k) % NREQ;
      if (!any && valid[IW'(pos)]) begin
        any              = 1'b1;
        idx              = IW'(pos);
        grant[IW'(pos)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shared UART TX: round-robin byte arbitration and 16x-oversampled serialization.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic                      clk_50MHz,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DBIT-1:0]      req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      tx
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned NW = width_of(DBIT);
  localparam logic [SCNT_W-1:0] OS_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] SB_LAST = SCNT_W'(SB_TICK - 1);
  localparam logic [NW-1:0]     BIT_LAST = NW'(DBIT - 1);

  logic [2:0]        state, state_n;
  logic [SCNT_W-1:0] s_cnt, s_cnt_n;
  logic [NW-1:0]     n_cnt, n_cnt_n;
  logic [DBIT-1:0]   sreg, sreg_n;
  logic [IW-1:0]     last, last_n, grant_id_n;
  logic              busy_n, tx_n;
  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              accept;
`ifdef UART_TX_PARITY_EN
  logic              par, par_n;
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .valid (req_valid),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign req_ready = (state == ST_IDLE && !reset) ? arb_grant : '0;
  assign accept    = (state == ST_IDLE) && !reset && arb_any;

  // Next-state and datapath; tx_n reflects the current state so tx lags the FSM by one clock.
  always_comb begin
    state_n    = state;
    s_cnt_n    = s_cnt;
    n_cnt_n    = n_cnt;
    sreg_n     = sreg;
    last_n     = last;
    grant_id_n = grant_id;
    busy_n     = busy;
    tx_n       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n      = par;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sreg_n     = req_data[arb_idx*DBIT +: DBIT];
          grant_id_n = arb_idx;
          last_n     = arb_idx;
          s_cnt_n    = '0;
          busy_n     = 1'b1;
          state_n    = ST_START;
`ifdef UART_TX_PARITY_EN
          par_n      = ^req_data[arb_idx*DBIT +: DBIT];
`endif
        end
      end
      ST_START: begin
        tx_n = 1'b0;
        if (tick) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_n = '0;
            n_cnt_n = '0;
            state_n = ST_DATA;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        tx_n = sreg[0];
        if (tick) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_n = '0;
            sreg_n  = sreg >> 1;
            if (n_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              n_cnt_n = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_n = par;
        if (tick) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_n = '0;
            state_n = ST_STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (s_cnt == SB_LAST) begin
            s_cnt_n = '0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      sreg     <= '0;
      last     <= IW'(NREQ - 1);
      grant_id <= '0;
      busy     <= 1'b0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      s_cnt    <= s_cnt_n;
      n_cnt    <= n_cnt_n;
      sreg     <= sreg_n;
      last     <= last_n;
      grant_id <= grant_id_n;
      busy     <= busy_n;
      tx       <= tx_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: predicted frames queued at accept, checked by a line receiver.
module tb_uart_tx_scheduler;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DBIT    = 8;
  localparam int unsigned SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME_TICKS = 16 * (1 + DBIT + PBITS) + SB_TICK;

  typedef struct packed {
    logic [1:0]      id;
    logic [DBIT-1:0] data;
  } frame_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 tick = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DBIT-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 tx;

  int checks = 0;
  int failures = 0;
  int tick_period = 2;
  int tc = 0;
  frame_t exp_q[$];

  uart_tx_scheduler #(.NREQ(NREQ), .DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk_50MHz (clk),
    .reset     (reset),
    .tick      (tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tc >= tick_period - 1) begin
      tc = 0;
      tick = 1'b1;
    end else begin
      tc++;
      tick = 1'b0;
    end
  end

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Next winner: scan requesters in order starting just after the last granted one.
  function automatic logic [NREQ-1:0] rr_model(input logic [NREQ-1:0] v, input int lst);
    logic [NREQ-1:0] g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (lst + k) % NREQ;
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Accept watcher: predicts req_ready, fairness, and queues the expected frame.
  int mlast = NREQ - 1;
  int waited[NREQ];
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int id;
    if (reset) begin
      mlast = NREQ - 1;
      for (int j = 0; j < NREQ; j++) waited[j] = 0;
    end else begin
      er = busy ? '0 : rr_model(req_valid, mlast);
      check(req_ready === er, "req_ready", longint'(req_ready), longint'(er));
      if (er != '0) begin
        id = 0;
        for (int j = 0; j < NREQ; j++) if (er[j]) id = j;
        check(waited[id] <= NREQ - 1, "fairness", longint'(waited[id]), longint'(NREQ - 1));
        for (int j = 0; j < NREQ; j++) if (j != id && req_valid[j]) waited[j]++;
        waited[id] = 0;
        exp_q.push_back('{id: 2'(id), data: req_data[id*DBIT +: DBIT]});
        mlast = id;
      end
    end
  end

  // Line monitor: frame length in ticks, idle gap, and mid-bit sampling of tx.
  int rx_on = 0;
  int tcnt = 0;
  int bt = 0;
  logic prev_busy = 1'b0;
  logic prev_tx = 1'b1;
  logic [DBIT-1:0] rx_data = '0;
  logic rx_par = 1'b0;
  always @(negedge clk) begin
    int k;
    frame_t e;
    if (reset) begin
      rx_on = 0; tcnt = 0; bt = 0;
      prev_busy = 1'b0; prev_tx = 1'b1;
      exp_q.delete();
    end else begin
      if (busy && !prev_busy) begin
        check(tx && prev_tx, "idle_gap_tx", longint'({prev_tx, tx}), 64'h3);
        bt = 0;
      end
      if (busy && tick) bt++;
      if (!busy && prev_busy) check(bt == FRAME_TICKS, "frame_ticks", longint'(bt), longint'(FRAME_TICKS));
      if (rx_on == 0) begin
        if (!tx && prev_tx) begin
          rx_on = 1;
          tcnt = 0;
        end
      end else if (tick) begin
        tcnt++;
        if (tcnt == 8) begin
          check(tx == 1'b0, "start_bit", longint'(tx), 0);
        end else if (tcnt > 8 && (tcnt - 8) % 16 == 0) begin
          k = (tcnt - 8) / 16;
          if (k <= DBIT) rx_data[k-1] = tx;
          else if (PBITS == 1 && k == DBIT + 1) rx_par = tx;
          else begin
            check(tx == 1'b1, "stop_bit", longint'(tx), 1);
            if (exp_q.size() == 0) begin
              check(1'b0, "unexpected_frame", longint'(rx_data), 0);
            end else begin
              e = exp_q.pop_front();
              check(rx_data == e.data, "frame_data", longint'(rx_data), longint'(e.data));
              check(grant_id == e.id, "grant_id", longint'(grant_id), longint'(e.id));
`ifdef UART_TX_PARITY_EN
              check(rx_par == ^e.data, "parity", longint'(rx_par), longint'(^e.data));
`endif
            end
            rx_on = 0;
          end
        end
      end
      prev_busy = busy;
      prev_tx = tx;
    end
  end

  // One clock: handshakes seen before the edge retire their valid right after it.
  task automatic step();
    logic [NREQ-1:0] h;
    @(negedge clk);
    h = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~h;
  endtask

  task automatic post(input int i, input logic [DBIT-1:0] d);
    if (!req_valid[i]) begin
      req_data[i*DBIT +: DBIT] = d;
      req_valid[i] = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((req_valid != '0 || busy || exp_q.size() != 0 || rx_on != 0) && n < 20000) begin
      step();
      n++;
    end
    check(n < 20000, "idle_timeout", longint'(n), 20000);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 2000) begin
      step();
      n++;
    end
    check(n < 2000, "busy_timeout", longint'(n), 2000);
  endtask

  task automatic run_ticks(input int nt);
    int c = 0;
    int n = 0;
    while (c < nt && n < 5000) begin
      step();
      if (tick) c++;
      n++;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check(tx == 1'b1, "reset_tx", longint'(tx), 1);
    check(busy == 1'b0, "reset_busy", longint'(busy), 0);
    check(grant_id == 2'd0, "reset_grant_id", longint'(grant_id), 0);
    check(req_ready == '0, "reset_req_ready", longint'(req_ready), 0);

    // Single 0x55 frame from requester 0.
    post(0, 8'h55);
    wait_idle();

    // All requesters valid: rotating order, then requester 0 again.
    tick_period = 1;
    for (int i = 0; i < NREQ; i++) post(i, 8'hA0 + 8'(i));
    n = 0;
    while (req_valid[0] && n < 100) begin step(); n++; end
    post(0, 8'hA4);
    wait_idle();

    // Requester 2 arrives mid-frame of requester 0.
    tick_period = 3;
    post(0, 8'h11);
    wait_busy();
    run_ticks(50);
    post(2, 8'h3C);
    wait_idle();

    // Reset at tick 70 of a frame; pending requesters 0 and 1, requester 0 must win afterwards.
    tick_period = 2;
    post(3, 8'hE7);
    wait_busy();
    run_ticks(70);
    post(1, 8'h81);
    post(0, 8'h5A);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check(tx == 1'b1, "midreset_tx", longint'(tx), 1);
    check(busy == 1'b0, "midreset_busy", longint'(busy), 0);
    check(req_ready == '0, "midreset_req_ready", longint'(req_ready), 0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check(req_ready == 4'b0001, "post_reset_winner", longint'(req_ready), 1);
    wait_idle();

    // Tick period 4 frame, then randomized traffic.
    tick_period = 4;
    post(2, 8'h07);
    wait_idle();
    for (int ph = 0; ph < 6; ph++) begin
      tick_period = $urandom_range(1, 3);
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < NREQ; i++)
          if (!req_valid[i] && $urandom_range(0, 99) < 2) post(i, 8'($urandom));
        step();
      end
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
